avg_pool_ctrl: RTL and testbench
================================

AVG_POOL_CTRL -- requirements
Module: avg_pool_ctrl

Interface
REQ-001 SHALL have parameter KernelWidth, default 2: pooling window edge; KernelWidth*KernelWidth SHALL be a power of 2.
REQ-002 SHALL have parameter WidthIn, default 8: pixel width in bits.
REQ-003 SHALL have parameter LineWidth, default 640: pixels per line; SHALL be a multiple of KernelWidth.
REQ-004 SHALL have parameter FrameHeight, default 480: lines per frame; SHALL be a multiple of KernelWidth.
REQ-005 SHALL have port clk_i, input, 1: single clock; one clock domain; all state on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port valid_i, input, 1: input pixel valid.
REQ-008 SHALL have port ready_o, output, 1: block accepts the input pixel.
REQ-009 SHALL have port data_i, input, WidthIn: raster-order input pixel.
REQ-010 SHALL have port valid_o, output, 1: pooled pixel valid.
REQ-011 SHALL have port ready_i, input, 1: downstream accepts the pooled pixel.
REQ-012 SHALL have port data_o, output, WidthIn: pooled pixel.
REQ-013 SHALL have port frame_done_o, output, 1: one-cycle pulse on acceptance of the last output pixel of a frame.

Function
REQ-014 Input transfer SHALL occur only on valid_i && ready_o; output transfer SHALL occur only on valid_o && ready_i.
REQ-015 ready_o SHALL equal !(valid_o && !ready_i); no combinational path from valid_i to ready_o.
REQ-016 The block SHALL keep a column counter col_q (0..LineWidth-1), a band-row counter row_q (0..KernelWidth-1) and a band counter band_q (0..FrameHeight/KernelWidth-1); each SHALL advance only on an input transfer and wrap to 0.
REQ-017 FSM states SHALL be S_FILL (row_q < KernelWidth-1) and S_EMIT (row_q == KernelWidth-1).
- S_FILL -> S_EMIT when col_q wraps and row_q reaches KernelWidth-1.
- S_EMIT -> S_FILL when col_q wraps at LineWidth-1.
REQ-018 In S_FILL, every accepted pixel SHALL be written to line buffer row_q at address col_q; no output SHALL be produced.
REQ-019 In S_EMIT, accepted pixels with col_q mod KernelWidth != KernelWidth-1 SHALL shift into a (KernelWidth-1)-deep horizontal register.
REQ-020 In S_EMIT, an accepted pixel with col_q mod KernelWidth == KernelWidth-1 SHALL complete the window: element r*KernelWidth+k = pixel(band row r, column col_q-KernelWidth+1+k).
REQ-021 The completed window SHALL pass through the avg datapath; the result SHALL be registered into data_o, and valid_o SHALL be set the cycle after the completing input transfer (latency 1).
REQ-022 data_o SHALL equal floor(sum of window / KernelWidth^2) with no rounding and no saturation; the intermediate sum SHALL be wide enough that it never overflows.
REQ-023 valid_o and data_o SHALL hold stable while valid_o && !ready_i.
REQ-024 If a new window completes in the same cycle that the held output is accepted, valid_o SHALL stay 1 and data_o SHALL take the new value.
REQ-025 frame_done_o SHALL pulse for one cycle on the output transfer of the window where band_q, col_q and row_q were all at their maxima; counters SHALL then be back at 0 in S_FILL.
REQ-026 Line-buffer contents SHALL NOT be cleared between bands or frames; every location SHALL be rewritten before it is read.

Reset
REQ-027 While rst_ni is low: valid_o=0, data_o=0, frame_done_o=0, ready_o=1, col_q/row_q/band_q=0, state=S_FILL.
REQ-028 Reset asserted mid-frame SHALL discard any partial window and held output; the first pixel after release SHALL be treated as pixel (0,0).

Structure
REQ-029 The FSM state enum and the window-index helper SHALL be in a shared package (avg_pool_pkg).
REQ-030 The block SHALL instantiate exactly one avg sub-module (KernelWidth, WidthIn) as the arithmetic datapath; the line buffers SHALL be inferred memories, (KernelWidth-1) x LineWidth x WidthIn.

Verification
Parameters for all scenarios: KernelWidth=2, WidthIn=8, LineWidth=4, FrameHeight=2.
REQ-031 Line0 = 10,20,30,40; line1 = 50,60,70,80; ready_i=1 -> data_o=35 then 55, each one cycle after pixels 60 and 80; frame_done_o pulses with the 55.
REQ-032 All pixels 255 -> both outputs 255, with no overflow.
REQ-033 Window 1,1,1,2 -> data_o=1 (truncation).
REQ-034 ready_i=0 held for 5 cycles after the first output -> valid_o=1 and data_o=35 stable, ready_o=0, no input accepted; release -> stream resumes with no loss.
REQ-035 valid_i toggled randomly over 3 frames -> outputs identical to the gap-free golden model; frame_done_o pulses exactly 3 times.
REQ-036 rst_ni pulsed after 6 pixels, then a full clean frame -> valid_o=0 during reset; the outputs match REQ-031 exactly.

Source files
------------

// File: rtl/avg_pool_pkg.sv
// Shared types and helpers for the average-pooling controller.
package avg_pool_pkg;

  // S_FILL: collecting the upper rows of a band into the line buffers.
  // S_EMIT: streaming the last row of a band and producing pooled pixels.
  typedef enum logic {
    S_FILL = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  // Flat position of window element (band row r, horizontal offset k).
  function automatic int unsigned win_idx(input int unsigned r,
                                          input int unsigned k,
                                          input int unsigned kw);
    return r * kw + k;
  endfunction

endpackage

// File: rtl/avg_pool_ctrl_avg.sv
// Arithmetic datapath: truncating mean of a KernelWidth x KernelWidth window.
module avg_pool_ctrl_avg #(
  parameter int KernelWidth = 2,
  parameter int WidthIn     = 8
) (
  input  logic [KernelWidth*KernelWidth*WidthIn-1:0] window,
  output logic [WidthIn-1:0]                         avg
);

  localparam int Win   = KernelWidth * KernelWidth;
  localparam int Shift = $clog2(Win);
  // Guard bits cover the worst case of every element at full scale.
  localparam int SumW  = WidthIn + Shift;

  logic [Win*WidthIn-1:0] rest;
  logic [SumW-1:0]        sum;

  // Sum all elements, then divide by the power-of-two element count (floor).
  always_comb begin
    rest = window;
    sum  = '0;
    for (int i = 0; i < Win; i++) begin
      sum  = sum + SumW'(rest[WidthIn-1:0]);
      rest = rest >> WidthIn;
    end
    avg = WidthIn'(sum >> Shift);
  end

endmodule

// File: rtl/avg_pool_ctrl.sv
// Streaming KxK average-pooling controller for raster-order pixels.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_FILL | band rows 0..K-2: pixels are stored in the line buffers
// S_EMIT | band row K-1: pixels complete windows, pooled output made
module avg_pool_ctrl
  import avg_pool_pkg::*;
#(
  parameter int KernelWidth = 2,
  parameter int WidthIn     = 8,
  parameter int LineWidth   = 640,
  parameter int FrameHeight = 480
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WidthIn-1:0] data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WidthIn-1:0] data_o,
  output logic               frame_done_o
);

  localparam int Win     = KernelWidth * KernelWidth;
  localparam int ColW    = (LineWidth > 1) ? $clog2(LineWidth) : 1;
  localparam int RowW    = (KernelWidth > 1) ? $clog2(KernelWidth) : 1;
  localparam int BandN   = FrameHeight / KernelWidth;
  localparam int BandW   = (BandN > 1) ? $clog2(BandN) : 1;
  localparam int LbDepth = (KernelWidth - 1) * LineWidth;
  localparam int AddrW   = (LbDepth > 1) ? $clog2(LbDepth) : 1;

  state_e                                    state;
  logic [ColW-1:0]                           col_q;
  logic [RowW-1:0]                           row_q;
  logic [BandW-1:0]                          band_q;
  logic [RowW-1:0]                           phase_q;
  logic [KernelWidth-2:0][WidthIn-1:0]       hreg;
  logic [KernelWidth-2:0][WidthIn-1:0]       hreg_shift;
  logic [WidthIn-1:0]                        line_mem [LbDepth];
  logic [AddrW-1:0]                          wr_addr;
  logic [Win-1:0][WidthIn-1:0]               window;
  logic [WidthIn-1:0]                        avg_out;
  logic                                      last_q;
  logic                                      accept;
  logic                                      col_last;
  logic                                      row_last;
  logic                                      band_last;
  logic                                      phase_last;
  logic                                      complete;

  // Stall input only while a pooled pixel is held; valid_i never feeds ready_o.
  assign ready_o      = !(valid_o && !ready_i);
  assign accept       = valid_i && ready_o;
  assign col_last     = (col_q == ColW'(LineWidth - 1));
  assign row_last     = (row_q == RowW'(KernelWidth - 1));
  assign band_last    = (band_q == BandW'(BandN - 1));
  // phase_q tracks col_q mod KernelWidth without a divider.
  assign phase_last   = (phase_q == RowW'(KernelWidth - 1));
  assign complete     = accept && (state == S_EMIT) && phase_last;
  assign frame_done_o = valid_o && ready_i && last_q;
  assign wr_addr      = AddrW'(int'(row_q) * LineWidth + int'(col_q));

  // Horizontal register keeps the oldest pixel of the current window in slot 0.
  if (KernelWidth == 2) begin : g_hshift_one
    assign hreg_shift = data_i;
  end else begin : g_hshift_many
    assign hreg_shift = {data_i, hreg[KernelWidth-2:1]};
  end

  // Window assembly: upper rows from the line buffers, last row from hreg + data_i.
  for (genvar r = 0; r < KernelWidth; r++) begin : g_row
    for (genvar k = 0; k < KernelWidth; k++) begin : g_col
      if (r < KernelWidth - 1) begin : g_mem
        logic [AddrW-1:0] rd_addr;
        assign rd_addr = AddrW'(r * LineWidth + int'(col_q) - (KernelWidth - 1 - k));
        assign window[win_idx(r, k, KernelWidth)] = line_mem[rd_addr];
      end else if (k < KernelWidth - 1) begin : g_hreg
        assign window[win_idx(r, k, KernelWidth)] = hreg[k];
      end else begin : g_live
        assign window[win_idx(r, k, KernelWidth)] = data_i;
      end
    end
  end

  avg_pool_ctrl_avg #(
    .KernelWidth(KernelWidth),
    .WidthIn    (WidthIn)
  ) u_avg (
    .window(window),
    .avg   (avg_out)
  );

  // Line buffers hold no reset; every location is rewritten in S_FILL before S_EMIT reads it.
  always_ff @(posedge clk_i) begin
    if (accept && (state == S_FILL)) begin
      line_mem[wr_addr] <= data_i;
    end
  end

  // Raster counters, FSM, horizontal register and registered pooled output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_FILL;
      col_q   <= '0;
      row_q   <= '0;
      band_q  <= '0;
      phase_q <= '0;
      hreg    <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      last_q  <= 1'b0;
    end else begin
      if (accept) begin
        phase_q <= phase_last ? '0 : phase_q + 1'b1;
        if (col_last) begin
          col_q <= '0;
          if (row_last) begin
            row_q  <= '0;
            band_q <= band_last ? '0 : band_q + 1'b1;
            state  <= S_FILL;
          end else begin
            row_q <= row_q + 1'b1;
            if (row_q == RowW'(KernelWidth - 2)) begin
              state <= S_EMIT;
            end
          end
        end else begin
          col_q <= col_q + 1'b1;
        end
        if ((state == S_EMIT) && !phase_last) begin
          hreg <= hreg_shift;
        end
      end
      // A fresh window may replace a held result in the same cycle it is taken.
      if (complete) begin
        valid_o <= 1'b1;
        data_o  <= avg_out;
        last_q  <= col_last && band_last;
      end else if (ready_i) begin
        valid_o <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avg_pool_ctrl.sv
// Directed bench for avg_pool_ctrl with a 2x2 kernel over a 4x2 frame.
module tb_avg_pool_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b1;
  logic [7:0] data_i = '0;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] data_o;
  logic       frame_done_o;

  int         checks = 0;
  int         errors = 0;
  int         fd_total = 0;
  int         in_total = 0;
  logic [7:0] out_q [$];
  bit         fd_q [$];
  logic [7:0] frame_px [8];

  avg_pool_ctrl #(
    .KernelWidth(2),
    .WidthIn    (8),
    .LineWidth  (4),
    .FrameHeight(2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  // Transfers are sampled mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o && ready_i) begin
        out_q.push_back(data_o);
        fd_q.push_back(frame_done_o);
      end
      if (frame_done_o) fd_total++;
      if (valid_i && ready_o) in_total++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic send_pixel(input logic [7:0] d);
    bit acc;
    acc = 1'b0;
    valid_i = 1'b1;
    data_i  = d;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = ready_o;
      next_cycle();
    end
    valid_i = 1'b0;
    data_i  = 8'($urandom_range(0, 255));
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic send_frame(input int gap_max);
    for (int i = 0; i < 8; i++) begin
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      send_pixel(frame_px[i]);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1);
    check({tag, "_count"}, 32'(out_q.size()), 32'd2);
    if (out_q.size() > 0) begin
      check({tag, "_out0"}, 32'(out_q[0]), 32'(e0));
      check({tag, "_fd0"}, 32'(fd_q[0]), 32'd0);
    end
    if (out_q.size() > 1) begin
      check({tag, "_out1"}, 32'(out_q[1]), 32'(e1));
      check({tag, "_fd1"}, 32'(fd_q[1]), 32'd1);
    end
    out_q.delete();
    fd_q.delete();
  endtask

  initial begin
    int         hold_in;
    int         fd_before;
    logic [7:0] e0;
    logic [7:0] e1;

    // Reset values
    idle(2);
    @(negedge clk);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_fd", 32'(frame_done_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    ready_i = 1'b0;
    #1;
    check("rst_ready_bp", 32'(ready_o), 32'd1);
    ready_i = 1'b1;
    next_cycle();
    rst_n = 1'b1;
    idle(1);

    // Basic frame with latency and frame_done alignment
    frame_px = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    for (int i = 0; i < 5; i++) send_pixel(frame_px[i]);
    @(negedge clk);
    check("pre60_valid", 32'(valid_o), 32'd0);
    next_cycle();
    send_pixel(8'd60);
    @(negedge clk);
    check("lat60_valid", 32'(valid_o), 32'd1);
    check("lat60_data", 32'(data_o), 32'd35);
    check("lat60_fd", 32'(frame_done_o), 32'd0);
    next_cycle();
    send_pixel(8'd70);
    @(negedge clk);
    check("post35_valid", 32'(valid_o), 32'd0);
    next_cycle();
    send_pixel(8'd80);
    @(negedge clk);
    check("lat80_valid", 32'(valid_o), 32'd1);
    check("lat80_data", 32'(data_o), 32'd55);
    check("lat80_fd", 32'(frame_done_o), 32'd1);
    next_cycle();
    @(negedge clk);
    check("after_valid", 32'(valid_o), 32'd0);
    check("after_fd", 32'(frame_done_o), 32'd0);
    next_cycle();
    check_frame("basic", 8'd35, 8'd55);

    // Full-scale pixels must not overflow
    frame_px = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    send_frame(0);
    idle(3);
    check_frame("fullscale", 8'd255, 8'd255);

    // Truncation: 5/4 -> 1, 18/4 -> 4
    frame_px = '{8'd1, 8'd1, 8'd3, 8'd4, 8'd1, 8'd2, 8'd5, 8'd6};
    send_frame(0);
    idle(3);
    check_frame("trunc", 8'd1, 8'd4);

    // Backpressure: hold the first result for 5 cycles
    frame_px = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    for (int i = 0; i < 5; i++) send_pixel(frame_px[i]);
    ready_i = 1'b0;
    send_pixel(8'd60);
    valid_i = 1'b1;
    data_i  = 8'd70;
    hold_in = in_total;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_valid", 32'(valid_o), 32'd1);
      check("hold_data", 32'(data_o), 32'd35);
      check("hold_ready", 32'(ready_o), 32'd0);
      next_cycle();
    end
    check("hold_no_input", 32'(in_total), 32'(hold_in));
    ready_i = 1'b1;
    send_pixel(8'd70);
    send_pixel(8'd80);
    idle(3);
    check_frame("backpressure", 8'd35, 8'd55);

    // Three frames with random input gaps against a reference average
    fd_before = fd_total;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) frame_px[i] = 8'($urandom_range(0, 255));
      e0 = 8'((int'(frame_px[0]) + int'(frame_px[1]) + int'(frame_px[4]) + int'(frame_px[5])) / 4);
      e1 = 8'((int'(frame_px[2]) + int'(frame_px[3]) + int'(frame_px[6]) + int'(frame_px[7])) / 4);
      send_frame(2);
      idle(3);
      check_frame("gappy", e0, e1);
    end
    check("gappy_fd_count", 32'(fd_total - fd_before), 32'd3);

    // Reset mid-frame with a held output, then a clean frame
    frame_px = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    for (int i = 0; i < 5; i++) send_pixel(frame_px[i]);
    ready_i = 1'b0;
    send_pixel(8'd60);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_data", 32'(data_o), 32'd0);
    check("midrst_fd", 32'(frame_done_o), 32'd0);
    check("midrst_ready", 32'(ready_o), 32'd1);
    ready_i = 1'b1;
    next_cycle();
    rst_n = 1'b1;
    out_q.delete();
    fd_q.delete();
    idle(1);
    send_frame(0);
    idle(3);
    check_frame("post_reset", 8'd35, 8'd55);
    check("fd_total", 32'(fd_total), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
